fetch_pair_queue: RTL and testbench

- Dual-issue fetch front end.
- Issues 8-byte-aligned requests to instruction memory and buffers returned instruction pairs in a FIFO.
- Presents each pair as instA/instB to the decode stage.
- Flushes on a control-flow redirect. When no valid pair is available, decode receives NOP bubbles.

---
 rtl/fetch_pair_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_pair_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_queue.sv
// Dual-issue fetch front end: issues 8-byte-aligned fetches and queues the
// returned instruction pairs for decode. Redirects flush and drop stale data.
module fetch_pair_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [63:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instA,
  output logic [31:0] o_instB,
  output logic [31:0] o_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] pc;
    logic        skip;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic          skip_pend_q, skip_pend_d;

  logic [SW-1:0] credit_used;
  logic          grant, push, pop, resp_drop;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^i_redirect_pc[1:0];

  // Every slot is charged at grant time, including responses still to be dropped,
  // so a response can never arrive to a full queue.
  assign credit_used = SW'(count_q) + SW'(outst_q) + SW'(drop_q);
  assign o_imem_req  = i_rst_n && (credit_used < SW'(DEPTH)) && !i_redirect;
  assign o_imem_addr = fetch_pc_q;

  assign grant     = o_imem_req && i_imem_gnt;
  assign resp_drop = i_imem_rvalid && (drop_q != '0);
  assign push      = i_imem_rvalid && (drop_q == '0) && !i_redirect;
  assign o_valid   = (count_q != '0);
  assign pop       = o_valid && i_ready && !i_redirect;
  assign head      = mem_q[head_q];

  always_comb begin
    o_instA = NOP;
    o_instB = NOP;
    o_pc    = last_pc_q;
    if (o_valid) begin
      o_instA = head.skip ? NOP : head.data[31:0];
      o_instB = head.data[63:32];
      o_pc    = head.skip ? head.pc + 32'd4 : head.pc;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    fetch_pc_d  = fetch_pc_q;
    resp_pc_d   = resp_pc_q;
    skip_pend_d = skip_pend_q;
    last_pc_d   = o_valid ? o_pc : last_pc_q;

    if (i_redirect) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      outst_d     = '0;
      // Everything still in flight becomes stale; a response arriving now is one of them.
      drop_d      = drop_q + outst_q - CW'(i_imem_rvalid);
      fetch_pc_d  = {i_redirect_pc[31:3], 3'b000};
      resp_pc_d   = {i_redirect_pc[31:3], 3'b000};
      skip_pend_d = i_redirect_pc[2];
    end else begin
      if (grant)     fetch_pc_d = fetch_pc_q + 32'd8;
      if (resp_drop) drop_d     = drop_q - 1'b1;
      if (push) begin
        tail_d      = tail_q + 1'b1;
        resp_pc_d   = resp_pc_q + 32'd8;
        skip_pend_d = 1'b0;
      end
      if (pop) head_d = head_q + 1'b1;

      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      case ({grant, push})
        2'b10:   outst_d = outst_q + 1'b1;
        2'b01:   outst_d = outst_q - 1'b1;
        default: outst_d = outst_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      drop_q      <= '0;
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      last_pc_q   <= RESET_PC;
      skip_pend_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      last_pc_q   <= last_pc_d;
      skip_pend_q <= skip_pend_d;
    end
  end

  // NOTE: the pair storage has no reset; occupancy is tracked by count_q, so stale contents are never presented.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[tail_q] <= '{data: i_imem_rdata, pc: resp_pc_q, skip: skip_pend_q};
    end
  end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Self-checking bench for fetch_pair_queue: memory responder model plus a
// scoreboard of expected decode pairs, one second instance for PC wrap.
module tb_fetch_pair_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_imem_gnt, i_imem_rvalid, i_redirect, i_ready;
  logic [63:0] i_imem_rdata;
  logic [31:0] i_redirect_pc;

  logic        o_imem_req, o_valid;
  logic [31:0] o_imem_addr, o_instA, o_instB, o_pc;
  logic        w_imem_req, w_valid;
  logic [31:0] w_imem_addr, w_instA, w_instB, w_pc;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  flight_t     inflight[$];
  pair_t       sb[$];
  logic [31:0] w_pcq[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          lat_cfg  = 1;
  int          grants   = 0;
  logic [31:0] exp_pc, last_pc_m, w_exp_addr;
  logic        skip_m, w_track, found;

  fetch_pair_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_instA(o_instA), .o_instB(o_instB), .o_pc(o_pc)
  );

  fetch_pair_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC), .NOP(NOP)) dut_w (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(w_imem_req), .o_imem_addr(w_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_valid(w_valid), .i_ready(i_ready),
    .o_instA(w_instA), .o_instB(w_instB), .o_pc(w_pc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic reset_models();
    sb.delete();
    inflight.delete();
    w_pcq.delete();
    exp_pc     = RESET_PC;
    last_pc_m  = RESET_PC;
    w_exp_addr = WRAP_PC;
    skip_m     = 1'b0;
    grants     = 0;
    epoch++;
  endtask

  // Called at a falling edge; holds reset for one cycle and releases it at the next falling edge.
  task automatic do_reset();
    i_rst_n       = 1'b0;
    i_imem_rvalid = 1'b0;
    i_redirect    = 1'b0;
    #1;
    check("rst_req", o_imem_req, 1'b0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_pc", o_pc, RESET_PC);
    @(negedge i_clk);
    reset_models();
    i_rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, update the model.
  task automatic run_cycle(input logic rdr, input logic [31:0] rdr_pc);
    flight_t f;
    pair_t   p;
    logic    have_resp, exp_req, exp_valid, live_push;
    have_resp = (inflight.size() != 0) && (inflight[0].due <= cyc);
    i_imem_rvalid = have_resp;
    if (have_resp) begin
      f = inflight[0];
      i_imem_rdata = {word_at(f.addr + 32'd4), word_at(f.addr)};
    end else begin
      i_imem_rdata = {$urandom, $urandom};
    end
    i_redirect    = rdr;
    i_redirect_pc = rdr_pc;
    #1;

    exp_req   = ((sb.size() + inflight.size()) < DEPTH) && !rdr;
    exp_valid = (sb.size() != 0);
    check("imem_req", o_imem_req, exp_req);
    if (exp_req) check("imem_addr", o_imem_addr, exp_pc);
    check("valid", o_valid, exp_valid);
    if (exp_valid) begin
      check("pc", o_pc, sb[0].pc);
      check("instA", o_instA, sb[0].a);
      check("instB", o_instB, sb[0].b);
      last_pc_m = sb[0].pc;
    end else begin
      check("empty_instA", o_instA, NOP);
      check("empty_instB", o_instB, NOP);
      check("empty_pc", o_pc, last_pc_m);
    end

    if (w_track) begin
      if (w_imem_req && i_imem_gnt) begin
        check("wrap_addr", w_imem_addr, w_exp_addr);
        w_pcq.push_back(w_exp_addr);
        w_exp_addr += 32'd8;
      end
      if (w_valid && i_ready) begin
        if (w_pcq.size() == 0) check("wrap_valid", w_valid, 1'b0);
        else check("wrap_pc", w_pc, w_pcq.pop_front());
      end
    end

    if (o_imem_req && i_imem_gnt) grants++;
    live_push = 1'b0;
    if (have_resp) begin
      void'(inflight.pop_front());
      if (f.epoch == epoch && !rdr) begin
        live_push = 1'b1;
        p.pc = skip_m ? f.addr + 32'd4 : f.addr;
        p.a  = skip_m ? NOP : word_at(f.addr);
        p.b  = word_at(f.addr + 32'd4);
        skip_m = 1'b0;
      end
    end

    if (rdr) begin
      sb.delete();
      epoch++;
      exp_pc = {rdr_pc[31:3], 3'b000};
      skip_m = rdr_pc[2];
    end else begin
      if (exp_valid && i_ready) void'(sb.pop_front());
      if (live_push) sb.push_back(p);
      if (exp_req && i_imem_gnt) begin
        inflight.push_back('{addr: exp_pc, epoch: epoch, due: cyc + lat_cfg});
        exp_pc += 32'd8;
      end
    end

    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_ready = 1'b0; w_track = 1'b0; found = 1'b0;
    reset_models();
    repeat (2) @(negedge i_clk);
    #1;
    check("init_req", o_imem_req, 1'b0);
    check("init_valid", o_valid, 1'b0);
    check("init_instA", o_instA, NOP);
    check("init_instB", o_instB, NOP);
    check("init_pc", o_pc, RESET_PC);
    check("init_wrap_pc", w_pc, WRAP_PC);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Streaming with single-cycle memory; the second instance shows the PC wrap.
    w_track = 1'b1; i_imem_gnt = 1'b1; i_ready = 1'b1; lat_cfg = 1;
    repeat (12) run_cycle(1'b0, '0);
    w_track = 1'b0;

    // Decode stalled: credits stop requests after DEPTH grants, then drain.
    do_reset();
    i_ready = 1'b0;
    repeat (10) run_cycle(1'b0, '0);
    check("stall_grants", grants, DEPTH);
    i_ready = 1'b1;
    repeat (10) run_cycle(1'b0, '0);

    // Redirect to an odd-word target with two fetches outstanding.
    do_reset();
    lat_cfg = 4;
    repeat (2) run_cycle(1'b0, '0);
    i_imem_gnt = 1'b0;
    run_cycle(1'b1, 32'h0000_0104);
    i_imem_gnt = 1'b1; lat_cfg = 1;
    repeat (16) run_cycle(1'b0, '0);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat_cfg = 2; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sb.size() != 0 && inflight.size() > 1 && inflight[0].due <= cyc) begin
        found = 1'b1;
        run_cycle(1'b1, 32'h0000_0200);
      end else begin
        run_cycle(1'b0, '0);
      end
    end
    check("redirect_window_found", found, 1'b1);
    repeat (10) run_cycle(1'b0, '0);

    // Random traffic: grant gaps, stalls, variable latency, occasional redirects.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_imem_gnt = ($urandom_range(0, 3) != 0);
      i_ready    = ($urandom_range(0, 2) != 0);
      lat_cfg    = $urandom_range(1, 4);
      run_cycle($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset with three pairs queued.
    do_reset();
    i_imem_gnt = 1'b1; i_ready = 1'b0; lat_cfg = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (sb.size() == 3) found = 1'b1;
      else run_cycle(1'b0, '0);
    end
    check("burst_fill", found, 1'b1);
    check("burst_valid_before_rst", o_valid, 1'b1);
    #2;
    i_rst_n = 1'b0;
    i_imem_rvalid = 1'b0;
    #1;
    check("async_valid", o_valid, 1'b0);
    check("async_instA", o_instA, NOP);
    check("async_instB", o_instB, NOP);
    check("async_req", o_imem_req, 1'b0);
    check("async_pc", o_pc, RESET_PC);
    @(negedge i_clk);
    reset_models();
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    repeat (10) run_cycle(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
